// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to excess-3 sequencing controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/bcd_to_excess3.sv
// Combinational single-digit BCD to excess-3 converter.
module bcd_to_excess3
    import bcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] e3
);

    assign e3 = bcd + E3_OFFSET;

endmodule

// File: rtl/bcd_e3_seq_ctrl.sv
// Converts a packed BCD word to excess-3 one digit per clock through one shared converter,
// with valid/ready handshakes on both sides.
module bcd_e3_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   e3_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   hold_q, hold_d;
    logic [4*DIGITS-1:0]   e3_q, e3_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;

    logic [3:0] digit;
    logic [3:0] conv_e3;
    logic       digit_bad;

    // The hold register shifts right each CONV cycle, so the current digit is always at [3:0].
    assign digit     = hold_q[3:0];
    assign digit_bad = (digit > BCD_MAX);

    bcd_to_excess3 u_conv (
        .bcd (digit),
        .e3  (conv_e3)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        e3_d        = e3_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = bcd_in;
                    e3_d    = '0;
                    err_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                e3_d[4*cnt_q +: 4] = digit_bad ? 4'b0000 : conv_e3;
                err_d[cnt_q]       = digit_bad;
                hold_d             = hold_q >> 4;
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            e3_q        <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            e3_q        <= e3_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign e3_out    = e3_q;
    assign digit_err = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_e3_seq_ctrl.sv
// Directed self-checking bench for bcd_e3_seq_ctrl with DIGITS=4.
module tb_bcd_e3_seq_ctrl;

    localparam int unsigned DIGITS = 4;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_in;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] e3_out;
    logic [DIGITS-1:0]   digit_err;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bcd_e3_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .e3_out    (e3_out),
        .digit_err (digit_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out_valid(input string tag, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    // Accept one word, check latency and result, optionally stall in DONE, then drain.
    task automatic run_word(input string tag, input logic [15:0] word, input logic [15:0] exp_e3,
                            input logic [3:0] exp_err, input int stall);
        int n;
        bcd_in   = word;
        in_valid = 1'b1;
        chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        bcd_in   = ~word;
        chk({tag, "_in_ready_conv"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_out_valid(tag, n);
        chk({tag, "_latency"}, 32'(n), 32'(DIGITS));
        chk({tag, "_e3"}, 32'(e3_out), 32'(exp_e3));
        chk({tag, "_err"}, 32'(digit_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            bcd_in   = 16'hFFFF;
            tick();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_e3"}, 32'(e3_out), 32'(exp_e3));
            chk({tag, "_stall_err"}, 32'(digit_err), 32'(exp_err));
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_e3"}, 32'(e3_out), 32'(exp_e3));
    endtask

    initial begin
        int n;
        int last_acc;
        logic [15:0] w;
        logic [15:0] x;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_e3", 32'(e3_out), 32'd0);
        chk("rst_err", 32'(digit_err), 32'd0);

        run_word("w1234", 16'h1234, 16'h4567, 4'b0000, 0);
        run_word("w0999", 16'h0999, 16'h3CCC, 4'b0000, 0);
        run_word("w9000", 16'h9000, 16'hC333, 4'b0000, 0);
        run_word("w12A9", 16'h12A9, 16'h450C, 4'b0010, 0);
        run_word("wFFFF", 16'hFFFF, 16'h0000, 4'b1111, 0);
        run_word("stall", 16'h1234, 16'h4567, 4'b0000, 5);

        // Abort a word with reset while the digit counter is at 2.
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_e3", 32'(e3_out), 32'd0);
        chk("abort_err", 32'(digit_err), 32'd0);
        run_word("w0001", 16'h0001, 16'h3334, 4'b0000, 0);

        // Continuous traffic: in_valid and out_ready held high, alternating words.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last_acc  = 0;
        for (int k = 0; k < 4; k++) begin
            w = (k % 2 == 0) ? 16'h0000 : 16'h9999;
            x = (k % 2 == 0) ? 16'h3333 : 16'hCCCC;
            bcd_in = w;
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            bcd_in = ~w;
            if (k > 0) chk("stream_spacing", 32'(cyc - last_acc), 32'(DIGITS + 2));
            last_acc = cyc;
            wait_out_valid("stream", n);
            chk("stream_e3", 32'(e3_out), 32'(x));
            chk("stream_err", 32'(digit_err), 32'd0);
        end
        tick();
        chk("stream_drain_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_e3_seq_ctrl.md
Name: bcd_e3_seq_ctrl

Overview:
Sequencing controller that converts a packed multi-digit BCD word to excess-3 one digit per clock through a single shared 4-bit converter. It accepts a word on a valid/ready input handshake and walks the digits LSB-first with a digit counter. It assembles the result, flags non-BCD digits, and presents the word on a valid/ready output handshake. It sits between a BCD source (counter/display path) and downstream excess-3 consumers, time-multiplexing one converter instead of instantiating DIGITS copies.

Parameters:
DIGITS, 4, number of BCD digits per word (legal 1..16)
CNT_W, $clog2(DIGITS) (min 1), digit-index counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; synchronous, active-low
in_valid  input  1  bcd_in holds a word to convert
in_ready  output  1  controller can accept a word
bcd_in  input  4*DIGITS  packed BCD; digit 0 = bits [3:0]
out_valid  output  1  e3_out/digit_err hold a completed result
out_ready  input  1  consumer accepts result
e3_out  output  4*DIGITS  packed excess-3 result, digit 0 = bits [3:0]
digit_err  output  DIGITS  bit i set if input digit i was >9
busy  output  1  high in CONV or DONE

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, counter=0, e3_out=0, digit_err=0, out_valid=0, in_ready=1, busy=0. Reset mid-CONV or mid-DONE aborts the word; no partial result is ever presented.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture bcd_in into an internal shift/hold register, clear the result and error registers, set counter=0, and go to CONV.
- CONV: in_ready=0. Each cycle convert digit[counter] and write the result slot [4*counter+:4] and digit_err[counter].
  - Digit 0..9: slot = digit+3 (4-bit, 0000->0011 ... 1001->1100), err bit 0.
  - Digit 10..15: slot forced to 4'b0000, err bit 1.
  - When counter==DIGITS-1, go to DONE in the same edge; otherwise counter+1.
- DONE: out_valid=1. e3_out and digit_err are stable and unchanged while out_valid&&!out_ready. On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: handshake accepted at edge t; out_valid is high after edge t+DIGITS. Throughput is one word per DIGITS+2 cycles with out_ready held high. in_ready is low from the accept edge until DONE exits, so no back-to-back accept occurs in the DONE->IDLE cycle.
- bcd_in changes after the accept edge do not affect the result.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- e3_out and digit_err hold the last result after the DONE handshake until the next accept clears them.
- All outputs are registered, except in_ready, which is decoded from state only and never depends on in_valid.
- The counter never exceeds DIGITS-1. If DIGITS=1, CONV lasts exactly one cycle.

Decomposition:
- Shared package bcd_pkg: state enum (IDLE/CONV/DONE, 2-bit encoding), localparam E3_OFFSET=4'd3, BCD_MAX=4'd9.
- One sub-module: the existing combinational bcd_to_excess3 (4-bit in, 4-bit out), instantiated once. The controller gates its output with the >9 check, so the sub-module's out-of-range behaviour is irrelevant.

Test Plan:
- DIGITS=4, reset, then bcd_in=16'h1234 with in_valid for 1 cycle: out_valid rises 4 cycles after accept; e3_out=16'h4567, digit_err=4'b0000.
- bcd_in=16'h0999: e3_out=16'h3CCC, digit_err=0. Then bcd_in=16'h9000: e3_out=16'hC333.
- bcd_in=16'h12A9: e3_out=16'h450C, digit_err=4'b0010. bcd_in=16'hFFFF: e3_out=16'h0000, digit_err=4'b1111.
- out_ready held low 5 cycles in DONE: out_valid, e3_out and digit_err are stable; in_ready stays 0; a new in_valid is ignored. Raise out_ready: IDLE next cycle, in_ready=1.
- Accept 16'h5678, drive rst_n=0 for one cycle at counter==2: all outputs are at reset values the next cycle. Then accept 16'h0001: result 16'h3334, with no residue from the aborted word.
- in_valid held high continuously with out_ready=1 and alternating words 16'h0000/16'h9999: results 16'h3333/16'hCCCC in order, one accept every DIGITS+2 cycles, no word lost or duplicated.
